// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channels between the MEM stage and the data memory
interface dmem_if #(parameter int ADDR_W = 32) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with fixed latency and byte-enabled stores
// Define DMEM_MISALIGN_EXC_EN to report illegal byte enables / misaligned accesses on resp_err.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [3:0] be_q;
  logic [IW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic we_q, ill_q, ill_d, rerr_q;
  logic accept, commit, unused_addr;
  assign bus.req_ready  = (state == IDLE) & rst;
  assign bus.resp_valid = state == RESP;
  assign bus.busy       = state != IDLE;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = rerr_q;
  assign accept = bus.req_valid & bus.req_ready;
  assign commit = (state == WAIT) && (cnt == 4'd0);
`ifdef DMEM_MISALIGN_EXC_EN
  assign ill_d = !(bus.req_be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
              || (bus.req_be == 4'b1111 && bus.req_addr[1:0] != 2'b00)
              || ((bus.req_be == 4'b0011 || bus.req_be == 4'b1100) && bus.req_addr[0]);
`else
  assign ill_d = 1'b0;
`endif
  // upper bits alias onto the array; the low two bits only matter for error checking
  assign unused_addr = ^{bus.req_addr[ADDR_W-1:IW+2], bus.req_addr[1:0]};
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? WAIT : IDLE;
      WAIT:    state_nx = (cnt == 4'd0) ? RESP : WAIT;
      RESP:    state_nx = bus.resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      rdata_q <= 32'd0;
      rerr_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        rdata_q <= (we_q || ill_q) ? 32'd0 : mem[idx_q];
        rerr_q  <= ill_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      idx_q   <= bus.req_addr[IW+1:2];
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
      ill_q   <= ill_d;
    end
  end
  // a reset on the commit edge drops the pending store
  always_ff @(posedge clk) begin
    if (rst && commit && we_q && !ill_q)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule
